// File: rtl/video_source_switch_if.sv
// Video source switch bus interface.
// Groups the channel inputs, the forwarded output stream and the switch status
// into one bundle. The clock and reset stay as plain ports on the switch.
//   master : stimulus side; drives sel/chan_*, observes out_*/status
//   slave  : switch side; reads sel/chan_*, drives out_*/status
// Optional macro VSS_FRAME_CNT_EN adds the frame_cnt status signal.
interface video_source_switch_if #(
    parameter int NCH   = 15,
    parameter int DW    = 16,
    parameter int SEL_W = 6
);
    logic [SEL_W-1:0]  sel;
    logic [NCH-1:0]    chan_valid;
    logic [NCH-1:0]    chan_sof;
    logic [NCH*DW-1:0] chan_data;
    logic              out_valid;
    logic              out_sof;
    logic [DW-1:0]     out_data;
    logic [SEL_W-1:0]  active_ch;
    logic              sw_busy;
    logic              sw_tmo;
`ifdef VSS_FRAME_CNT_EN
    logic [15:0]       frame_cnt;

    modport master (
        output sel, chan_valid, chan_sof, chan_data,
        input  out_valid, out_sof, out_data, active_ch, sw_busy, sw_tmo, frame_cnt
    );
    modport slave (
        input  sel, chan_valid, chan_sof, chan_data,
        output out_valid, out_sof, out_data, active_ch, sw_busy, sw_tmo, frame_cnt
    );
`else
    modport master (
        output sel, chan_valid, chan_sof, chan_data,
        input  out_valid, out_sof, out_data, active_ch, sw_busy, sw_tmo
    );
    modport slave (
        input  sel, chan_valid, chan_sof, chan_data,
        output out_valid, out_sof, out_data, active_ch, sw_busy, sw_tmo
    );
`endif
endinterface

// File: rtl/video_source_switch.sv
// Registered, frame-aligned video source switch for the SignalTab capture path.
// Forwards one of NCH same-clock channels with one cycle of latency. A change of
// the requested channel is held off until the new channel shows a start of
// frame; the output is blanked meanwhile, and a timeout forces the switch.
// Ports:
//   clk  : capture clock shared by all channels
//   rst  : asynchronous, active-low reset
//   bus  : video_source_switch_if.slave (sel, chan_*, out_*, active_ch,
//          sw_busy, sw_tmo and, with VSS_FRAME_CNT_EN, frame_cnt)
// Optional macro VSS_FRAME_CNT_EN: adds a 16-bit count of forwarded SOF beats,
// cleared on every completed switch.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_RUN  | forwarding active_ch; a new request moves to ST_PEND
// ST_PEND | output blanked, waiting for SOF on tgt or for the timeout
module video_source_switch #(
    parameter int             NCH     = 15,
    parameter int             DW      = 16,
    parameter int             SEL_W   = 6,
    parameter int             TMO_W   = 20,
    parameter logic [TMO_W-1:0] TMO_MAX = 20'hFFFFF
) (
    input  logic                  clk,
    input  logic                  rst,
    video_source_switch_if.slave  bus
);

    typedef enum logic {ST_RUN = 1'b0, ST_PEND = 1'b1} state_t;

    state_t           state_q,     state_d;
    logic [SEL_W-1:0] active_ch_q, active_ch_d;
    logic [SEL_W-1:0] tgt_q,       tgt_d;
    logic [TMO_W-1:0] tmo_cnt_q,   tmo_cnt_d;
    logic             out_valid_q, out_valid_d;
    logic             out_sof_q,   out_sof_d;
    logic [DW-1:0]    out_data_q,  out_data_d;
    logic             sw_tmo_q,    sw_tmo_d;
    logic             switch_done;

    logic [SEL_W-1:0] req;
    logic             act_valid, act_sof, tgt_valid, tgt_sof;
    logic [DW-1:0]    act_data, tgt_data;

    always_comb begin
        req = bus.sel;
        if (bus.sel == '0 || bus.sel > SEL_W'(NCH)) begin
            req = SEL_W'(1);
        end
    end

    // Compare-based selection keeps channel numbers 1-based and avoids
    // indexing past NCH with a wider selector.
    always_comb begin
        act_valid = 1'b0;
        act_sof   = 1'b0;
        act_data  = '0;
        tgt_valid = 1'b0;
        tgt_sof   = 1'b0;
        tgt_data  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (active_ch_q == SEL_W'(i + 1)) begin
                act_valid = bus.chan_valid[i];
                act_sof   = bus.chan_sof[i];
                act_data  = bus.chan_data[i*DW +: DW];
            end
            if (tgt_q == SEL_W'(i + 1)) begin
                tgt_valid = bus.chan_valid[i];
                tgt_sof   = bus.chan_sof[i];
                tgt_data  = bus.chan_data[i*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        active_ch_d = active_ch_q;
        tgt_d       = tgt_q;
        tmo_cnt_d   = tmo_cnt_q;
        out_valid_d = 1'b0;
        out_sof_d   = 1'b0;
        out_data_d  = out_data_q;
        sw_tmo_d    = sw_tmo_q;
        switch_done = 1'b0;
        case (state_q)
            ST_RUN: begin
                out_valid_d = act_valid;
                out_sof_d   = act_valid & act_sof;
                out_data_d  = act_data;
                if (req != active_ch_q) begin
                    state_d   = ST_PEND;
                    tgt_d     = req;
                    tmo_cnt_d = '0;
                end
            end
            ST_PEND: begin
                // Priority: abort, then retarget, then SOF, then timeout.
                if (req == active_ch_q) begin
                    state_d = ST_RUN;
                end else if (req != tgt_q) begin
                    tgt_d     = req;
                    tmo_cnt_d = '0;
                end else if (tgt_valid && tgt_sof) begin
                    // Forward the SOF beat itself so the new frame is complete.
                    state_d     = ST_RUN;
                    active_ch_d = tgt_q;
                    out_valid_d = 1'b1;
                    out_sof_d   = 1'b1;
                    out_data_d  = tgt_data;
                    switch_done = 1'b1;
                end else if (tmo_cnt_q == TMO_MAX) begin
                    state_d     = ST_RUN;
                    active_ch_d = tgt_q;
                    sw_tmo_d    = 1'b1;
                    switch_done = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            active_ch_q <= SEL_W'(1);
            tgt_q       <= SEL_W'(1);
            tmo_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_data_q  <= '0;
            sw_tmo_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            active_ch_q <= active_ch_d;
            tgt_q       <= tgt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            out_valid_q <= out_valid_d;
            out_sof_q   <= out_sof_d;
            out_data_q  <= out_data_d;
            sw_tmo_q    <= sw_tmo_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_sof   = out_sof_q;
    assign bus.out_data  = out_data_q;
    assign bus.active_ch = active_ch_q;
    assign bus.sw_busy   = (state_q == ST_PEND);
    assign bus.sw_tmo    = sw_tmo_q;

`ifdef VSS_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    // Counts with the same edge that registers out_sof, so the SOF beat that
    // completes a switch lands on top of the clear.
    always_comb begin
        frame_cnt_d = (switch_done ? 16'd0 : frame_cnt_q) + 16'(out_sof_d);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign bus.frame_cnt = frame_cnt_q;
`else
    // Without the frame counter, switch completion has no further consumer.
    logic unused_switch_done;
    assign unused_switch_done = switch_done;
`endif

endmodule

// File: tb/tb_video_source_switch.sv
module tb_video_source_switch;

    localparam int NCH   = 15;
    localparam int DW    = 16;
    localparam int SEL_W = 6;
    localparam int TMO_W = 20;
    localparam logic [TMO_W-1:0] TMO_MAX = 20'd100;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   bad;

    video_source_switch_if #(.NCH(NCH), .DW(DW), .SEL_W(SEL_W)) bus ();

    video_source_switch #(
        .NCH(NCH), .DW(DW), .SEL_W(SEL_W), .TMO_W(TMO_W), .TMO_MAX(TMO_MAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int ch, input logic v, input logic s, input logic [DW-1:0] d);
        bus.chan_valid[ch-1]          = v;
        bus.chan_sof[ch-1]            = s;
        bus.chan_data[(ch-1)*DW +: DW] = d;
    endtask

    task automatic clear_all();
        bus.chan_valid = '0;
        bus.chan_sof   = '0;
        bus.chan_data  = '0;
    endtask

    initial begin
        rst     = 1'b0;
        bus.sel = 6'd5;
        clear_all();

        // T1 reset
        tick();
        tick();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_sof",   32'(bus.out_sof),   32'd0);
        chk("rst_out_data",  32'(bus.out_data),  32'd0);
        chk("rst_active_ch", 32'(bus.active_ch), 32'd1);
        chk("rst_sw_busy",   32'(bus.sw_busy),   32'd0);
        chk("rst_sw_tmo",    32'(bus.sw_tmo),    32'd0);
`ifdef VSS_FRAME_CNT_EN
        chk("rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
`endif
        rst = 1'b1;
        tick();
        chk("t1_busy",   32'(bus.sw_busy),   32'd1);
        chk("t1_active", 32'(bus.active_ch), 32'd1);
        chk("t1_valid",  32'(bus.out_valid), 32'd0);

        // T5 abort and out-of-range mapping
        bus.sel = 6'd1;
        tick();
        chk("t5_abort_busy",   32'(bus.sw_busy),   32'd0);
        chk("t5_abort_active", 32'(bus.active_ch), 32'd1);
        bus.sel = 6'd4;
        tick();
        chk("t5_pend4_busy", 32'(bus.sw_busy), 32'd1);
        bus.sel = 6'd1;
        tick();
        chk("t5_back1_busy",   32'(bus.sw_busy),   32'd0);
        chk("t5_back1_active", 32'(bus.active_ch), 32'd1);
        bus.sel = 6'd0;
        tick();
        chk("t5_sel0_busy",   32'(bus.sw_busy),   32'd0);
        chk("t5_sel0_active", 32'(bus.active_ch), 32'd1);
        bus.sel = 6'd20;
        tick();
        chk("t5_sel20_busy",   32'(bus.sw_busy),   32'd0);
        chk("t5_sel20_active", 32'(bus.active_ch), 32'd1);

        // T2 passthrough on ch3
        bus.sel = 6'd3;
        drive(3, 1'b1, 1'b0, 16'hA5A5);
        tick();
        chk("t2_pend_busy", 32'(bus.sw_busy), 32'd1);
        drive(3, 1'b1, 1'b1, 16'h1111);
        tick();
        chk("t2_sw_active", 32'(bus.active_ch), 32'd3);
        chk("t2_sw_valid",  32'(bus.out_valid), 32'd1);
        chk("t2_sw_sof",    32'(bus.out_sof),   32'd1);
        chk("t2_sw_data",   32'(bus.out_data),  32'h1111);
        chk("t2_sw_busy",   32'(bus.sw_busy),   32'd0);
        drive(3, 1'b1, 1'b0, 16'hA5A5);
        tick();
        chk("t2_data",  32'(bus.out_data),  32'hA5A5);
        chk("t2_valid", 32'(bus.out_valid), 32'd1);
        chk("t2_sof",   32'(bus.out_sof),   32'd0);
        drive(3, 1'b0, 1'b1, 16'h5A5A);
        tick();
        chk("t2_inv_valid", 32'(bus.out_valid), 32'd0);
        chk("t2_inv_sof",   32'(bus.out_sof),   32'd0);
        chk("t2_inv_data",  32'(bus.out_data),  32'h5A5A);

        // T3 frame-aligned switch 3 -> 7
        drive(3, 1'b1, 1'b0, 16'h0300);
        drive(7, 1'b1, 1'b0, 16'h0700);
        bus.sel = 6'd7;
        tick();
        chk("t3_req_busy",  32'(bus.sw_busy),   32'd1);
        chk("t3_req_valid", 32'(bus.out_valid), 32'd1);
        chk("t3_req_data",  32'(bus.out_data),  32'h0300);
        bad = 0;
        for (int i = 0; i < 39; i++) begin
            tick();
            if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0300 ||
                bus.active_ch !== 6'd3 || bus.sw_busy !== 1'b1) bad++;
        end
        chk("t3_blank_cycles", 32'(bad), 32'd0);
        drive(7, 1'b1, 1'b1, 16'h7777);
        tick();
        chk("t3_sw_valid",  32'(bus.out_valid), 32'd1);
        chk("t3_sw_sof",    32'(bus.out_sof),   32'd1);
        chk("t3_sw_data",   32'(bus.out_data),  32'h7777);
        chk("t3_sw_active", 32'(bus.active_ch), 32'd7);
        chk("t3_sw_busy",   32'(bus.sw_busy),   32'd0);
`ifdef VSS_FRAME_CNT_EN
        chk("t3_frame_cnt", 32'(bus.frame_cnt), 32'd1);
`endif

        // T4 timeout toward ch9
        clear_all();
        bus.sel = 6'd9;
        tick();
        chk("t4_enter_busy", 32'(bus.sw_busy), 32'd1);
        repeat (100) tick();
        chk("t4_last_active", 32'(bus.active_ch), 32'd7);
        chk("t4_last_busy",   32'(bus.sw_busy),   32'd1);
        chk("t4_last_tmo",    32'(bus.sw_tmo),    32'd0);
        tick();
        chk("t4_tmo_active", 32'(bus.active_ch), 32'd9);
        chk("t4_tmo_flag",   32'(bus.sw_tmo),    32'd1);
        chk("t4_tmo_busy",   32'(bus.sw_busy),   32'd0);
        chk("t4_tmo_valid",  32'(bus.out_valid), 32'd0);
        drive(9, 1'b1, 1'b0, 16'h9999);
        tick();
        chk("t4_mid_valid", 32'(bus.out_valid), 32'd1);
        chk("t4_mid_data",  32'(bus.out_data),  32'h9999);
        tick();
        chk("t4_sticky", 32'(bus.sw_tmo), 32'd1);

        // req change wins over SOF on the old target
        clear_all();
        bus.sel = 6'd4;
        tick();
        chk("sim_pend_busy", 32'(bus.sw_busy), 32'd1);
        bus.sel = 6'd5;
        drive(4, 1'b1, 1'b1, 16'h4444);
        tick();
        chk("sim_retgt_active", 32'(bus.active_ch), 32'd9);
        chk("sim_retgt_busy",   32'(bus.sw_busy),   32'd1);
        clear_all();
        bus.sel = 6'd9;
        tick();
        chk("sim_abort_busy",   32'(bus.sw_busy),   32'd0);
        chk("sim_abort_active", 32'(bus.active_ch), 32'd9);

        // reset mid-PEND
        bus.sel = 6'd4;
        tick();
        chk("rpend_busy", 32'(bus.sw_busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("rpend_active", 32'(bus.active_ch), 32'd1);
        chk("rpend_sbusy",  32'(bus.sw_busy),   32'd0);
        chk("rpend_tmo",    32'(bus.sw_tmo),    32'd0);
        chk("rpend_valid",  32'(bus.out_valid), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        chk("rpend_re_busy",   32'(bus.sw_busy),   32'd1);
        chk("rpend_re_active", 32'(bus.active_ch), 32'd1);

        // SOF coincident with timeout: SOF path wins
        repeat (100) tick();
        drive(4, 1'b1, 1'b1, 16'h4444);
        tick();
        chk("sof_tmo_active", 32'(bus.active_ch), 32'd4);
        chk("sof_tmo_flag",   32'(bus.sw_tmo),    32'd0);
        chk("sof_tmo_sof",    32'(bus.out_sof),   32'd1);
        chk("sof_tmo_data",   32'(bus.out_data),  32'h4444);

        // T6 frame counting on ch2, then switch to ch6
        clear_all();
        bus.sel = 6'd2;
        drive(2, 1'b1, 1'b0, 16'h2000);
        tick();
        drive(2, 1'b1, 1'b1, 16'h2001);
        tick();
        chk("t6_sw2_active", 32'(bus.active_ch), 32'd2);
`ifdef VSS_FRAME_CNT_EN
        chk("t6_cnt_1", 32'(bus.frame_cnt), 32'd1);
`endif
        drive(2, 1'b1, 1'b0, 16'h2002);
        tick();
        drive(2, 1'b1, 1'b1, 16'h2003);
        tick();
        drive(2, 1'b1, 1'b0, 16'h2004);
        tick();
        drive(2, 1'b1, 1'b1, 16'h2005);
        tick();
        drive(2, 1'b1, 1'b0, 16'h2006);
        tick();
        chk("t6_ch2_data", 32'(bus.out_data), 32'h2006);
`ifdef VSS_FRAME_CNT_EN
        chk("t6_cnt_3", 32'(bus.frame_cnt), 32'd3);
`endif
        bus.sel = 6'd6;
        drive(6, 1'b1, 1'b0, 16'h6001);
        tick();
        chk("t6_pend6_busy", 32'(bus.sw_busy), 32'd1);
        drive(6, 1'b1, 1'b1, 16'h6000);
        tick();
        chk("t6_sw6_active", 32'(bus.active_ch), 32'd6);
        chk("t6_sw6_data",   32'(bus.out_data),  32'h6000);
`ifdef VSS_FRAME_CNT_EN
        chk("t6_cnt_after_sw", 32'(bus.frame_cnt), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
